// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encoding, default field widths and frame-length helpers.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ACK_ADDR,
        DATA,
        ACK_DATA,
        WAIT_STOP
    } i2c_state_e;

    localparam int I2C_ADDR_WIDTH_DEF = 7;
    localparam int I2C_DATA_WIDTH_DEF = 8;

    // START excluded: address + R/W + ACK + data + ACK
    localparam int I2C_FRAME_BITS_DEF = I2C_ADDR_WIDTH_DEF + 1 + 1 + I2C_DATA_WIDTH_DEF + 1;

    // Bit counter must reach address+R/W or data bits, whichever is longer.
    function automatic int bit_cnt_width(input int addr_w, input int data_w);
        int longest;
        longest = (addr_w + 1 > data_w) ? addr_w + 1 : data_w;
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/axis_if.sv
// AXI-Stream style handshake bundle (tvalid/tready/tdata) with master and slave views.
interface axis_if #(
    parameter int DATA_WIDTH = 16
) ();
    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;

    modport master (output tvalid, output tdata, input tready);
    modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/i2c_line_sync.sv
// Two-flop synchronizer plus edge register for scl/sda; derives scl edges and START/STOP.
module i2c_line_sync (
    input  logic clk,
    input  logic arstn,
    input  logic scl,
    input  logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_bit
);
    logic [1:0] scl_sync;
    logic [1:0] sda_sync;
    logic       scl_d;
    logic       sda_d;

    // Idle bus level is high, so reset everything to 1 to avoid phantom edges.
    always_ff @(posedge clk) begin
        if (!arstn) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], scl};
            sda_sync <= {sda_sync[0], sda};
            scl_d    <= scl_sync[1];
            sda_d    <= sda_sync[1];
        end
    end

    assign scl_rise  =  scl_sync[1] & ~scl_d;
    assign scl_fall  = ~scl_sync[1] &  scl_d;
    assign start_det =  scl_sync[1] &  scl_d & ~sda_sync[1] &  sda_d;
    assign stop_det  =  scl_sync[1] &  scl_d &  sda_sync[1] & ~sda_d;
    assign sda_bit   =  sda_sync[1];
endmodule

// File: rtl/axis_i2c_rx.sv
// I2C write-frame receiver: one address+R/W+data frame becomes one AXI-Stream word.
// Optional address filter: define AXIS_I2C_RX_ADDR_FILTER_EN to accept only OWN_ADDR.
module axis_i2c_rx
    import i2c_pkg::*;
#(
    parameter int                        I2C_ADDR_WIDTH  = I2C_ADDR_WIDTH_DEF,
    parameter int                        I2C_DATA_WIDTH  = I2C_DATA_WIDTH_DEF,
    parameter int                        AXIS_DATA_WIDTH = I2C_DATA_WIDTH * 2,
    parameter logic [I2C_ADDR_WIDTH-1:0] OWN_ADDR        = 7'h50
) (
    input  logic   clk,
    input  logic   arstn,
    input  logic   scl,
    input  logic   sda,
    output logic   sda_oe,
    output logic   overflow,
    axis_if.master m_axis
);
    localparam int CW = bit_cnt_width(I2C_ADDR_WIDTH, I2C_DATA_WIDTH);
    localparam int HW = I2C_ADDR_WIDTH + 1;

    i2c_state_e                state;
    logic [CW-1:0]             bit_cnt;
    logic [HW-1:0]             hdr_sh;
    logic [I2C_DATA_WIDTH-1:0] data_sh;
    logic                      ack_phase;
    logic                      ack_ok;
    logic                      scl_rise, scl_fall, start_det, stop_det, sda_bit;
    logic [HW-1:0]             hdr_next;
    logic [I2C_DATA_WIDTH-1:0] data_next;
    logic                      hdr_accept;

    i2c_line_sync u_sync (
        .clk       (clk),
        .arstn     (arstn),
        .scl       (scl),
        .sda       (sda),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det),
        .sda_bit   (sda_bit)
    );

    // LSB first: shift in at the top so the first bit lands in bit 0.
    assign hdr_next  = {sda_bit, hdr_sh[HW-1:1]};
    assign data_next = {sda_bit, data_sh[I2C_DATA_WIDTH-1:1]};

`ifdef AXIS_I2C_RX_ADDR_FILTER_EN
    assign hdr_accept = (hdr_next[I2C_ADDR_WIDTH-1:0] == OWN_ADDR);
`else
    logic unused_own_addr;
    assign unused_own_addr = ^OWN_ADDR;
    assign hdr_accept      = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!arstn) begin
            state         <= IDLE;
            bit_cnt       <= '0;
            hdr_sh        <= '0;
            data_sh       <= '0;
            ack_phase     <= 1'b0;
            ack_ok        <= 1'b0;
            sda_oe        <= 1'b0;
            overflow      <= 1'b0;
            m_axis.tvalid <= 1'b0;
            m_axis.tdata  <= '0;
        end else begin
            if (m_axis.tvalid && m_axis.tready)
                m_axis.tvalid <= 1'b0;

            if (stop_det) begin
                state     <= IDLE;
                bit_cnt   <= '0;
                ack_phase <= 1'b0;
                sda_oe    <= 1'b0;
            end else if (start_det) begin
                state     <= ADDR;
                bit_cnt   <= '0;
                ack_phase <= 1'b0;
                sda_oe    <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: ;
                    ADDR: if (scl_rise) begin
                        hdr_sh <= hdr_next;
                        if (bit_cnt == CW'(I2C_ADDR_WIDTH)) begin
                            bit_cnt   <= '0;
                            ack_phase <= 1'b0;
                            state     <= hdr_accept ? ACK_ADDR : WAIT_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + CW'(1);
                        end
                    end
                    // First scl fall opens the ACK slot, second one closes it.
                    ACK_ADDR: if (scl_fall) begin
                        if (!ack_phase) begin
                            sda_oe    <= 1'b1;
                            ack_phase <= 1'b1;
                        end else begin
                            sda_oe    <= 1'b0;
                            ack_phase <= 1'b0;
                            state     <= DATA;
                        end
                    end
                    DATA: if (scl_rise) begin
                        data_sh <= data_next;
                        if (bit_cnt == CW'(I2C_DATA_WIDTH - 1)) begin
                            bit_cnt   <= '0;
                            ack_phase <= 1'b0;
                            state     <= ACK_DATA;
                            // A word draining this very cycle frees the slot.
                            if (!m_axis.tvalid || m_axis.tready) begin
                                m_axis.tvalid <= 1'b1;
                                m_axis.tdata  <= AXIS_DATA_WIDTH'({data_next, hdr_sh});
                                ack_ok        <= 1'b1;
                            end else begin
                                overflow <= 1'b1;
                                ack_ok   <= 1'b0;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + CW'(1);
                        end
                    end
                    ACK_DATA: if (scl_fall) begin
                        if (!ack_phase) begin
                            sda_oe    <= ack_ok;
                            ack_phase <= 1'b1;
                        end else begin
                            sda_oe    <= 1'b0;
                            ack_phase <= 1'b0;
                            state     <= WAIT_STOP;
                        end
                    end
                    WAIT_STOP: ;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_axis_i2c_rx.sv
// Scoreboard bench for axis_i2c_rx: an I2C bus master model drives frames, a monitor checks beats.
module tb_axis_i2c_rx;
    logic clk   = 1'b0;
    logic arstn = 1'b0;
    logic scl_m = 1'b1;
    logic sda_m = 1'b1;
    logic sda_oe;
    logic overflow;
    logic sda_line;
    int   q_clk = 2;
    int   checks = 0;
    int   failures = 0;
    logic [15:0] exp_q[$];

    assign sda_line = sda_m & ~sda_oe;

    axis_if #(.DATA_WIDTH(16)) m_axis ();

    axis_i2c_rx #(
        .I2C_ADDR_WIDTH (7),
        .I2C_DATA_WIDTH (8),
        .AXIS_DATA_WIDTH(16),
        .OWN_ADDR       (7'h50)
    ) dut (
        .clk     (clk),
        .arstn   (arstn),
        .scl     (scl_m),
        .sda     (sda_line),
        .sda_oe  (sda_oe),
        .overflow(overflow),
        .m_axis  (m_axis.master)
    );

    always #5 clk = ~clk;

    // Monitor: every handshake beat must match the oldest expected word.
    always @(negedge clk) begin
        if (arstn && m_axis.tvalid === 1'b1 && m_axis.tready === 1'b1) begin
            checks = checks + 1;
            if (exp_q.size() == 0) begin
                failures = failures + 1;
                $display("FAIL beat_unexpected got=%h", m_axis.tdata);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if (m_axis.tdata !== e) begin
                    failures = failures + 1;
                    $display("FAIL beat_tdata got=%h exp=%h", m_axis.tdata, e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic wq();
        repeat (q_clk) @(negedge clk);
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk);
        #2 m_axis.tready = v;
    endtask

    task automatic bus_start();
        if (scl_m == 1'b0) begin
            wq(); sda_m = 1'b1; wq(); scl_m = 1'b1; wq();
        end
        sda_m = 1'b0; wq(); scl_m = 1'b0;
    endtask

    task automatic bus_bit(input logic b);
        wq(); sda_m = b; wq(); scl_m = 1'b1; wq(); wq(); scl_m = 1'b0;
    endtask

    task automatic bus_ack(output logic ack);
        wq(); sda_m = 1'b1; wq(); scl_m = 1'b1; wq(); ack = ~sda_line; wq(); scl_m = 1'b0;
    endtask

    task automatic bus_stop();
        wq(); sda_m = 1'b0; wq(); scl_m = 1'b1; wq(); sda_m = 1'b1; wq(); wq();
    endtask

    task automatic bus_header(input logic [6:0] addr, input logic rw);
        bus_start();
        for (int i = 0; i < 7; i++) bus_bit(addr[i]);
        bus_bit(rw);
    endtask

    task automatic frame(input logic [6:0] addr, input logic rw, input logic [7:0] data,
                         input logic exp_aack, input logic exp_dack, input string tag);
        logic a;
        logic d;
        bus_header(addr, rw);
        bus_ack(a);
        chk({tag, "_aack"}, {31'd0, a}, {31'd0, exp_aack});
        if (a) begin
            for (int i = 0; i < 8; i++) bus_bit(data[i]);
            bus_ack(d);
            chk({tag, "_dack"}, {31'd0, d}, {31'd0, exp_dack});
        end
        bus_stop();
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
        repeat (20) @(negedge clk);
        chk({tag, "_qempty"}, exp_q.size(), 0);
    endtask

    initial begin
        logic a;
        logic [7:0] part;
        m_axis.tready = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_sda_oe", {31'd0, sda_oe}, 0);
        chk("rst_tvalid", {31'd0, m_axis.tvalid}, 0);
        chk("rst_tdata", {16'd0, m_axis.tdata}, 0);
        chk("rst_overflow", {31'd0, overflow}, 0);
        arstn = 1'b1;
        repeat (10) @(negedge clk);

        // Basic write frame, both slots ACKed.
        exp_q.push_back(16'hA550);
        frame(7'h50, 1'b0, 8'hA5, 1'b1, 1'b1, "f034");
        drain("f034");
        chk("f034_overflow", {31'd0, overflow}, 0);

        // Foreign address: filtered build NACKs it, default build accepts it.
`ifdef AXIS_I2C_RX_ADDR_FILTER_EN
        frame(7'h23, 1'b0, 8'h5A, 1'b0, 1'b0, "f035");
`else
        exp_q.push_back(16'h5A23);
        frame(7'h23, 1'b0, 8'h5A, 1'b1, 1'b1, "f035");
`endif
        drain("f035");

        // STOP after four data bits, then a complete frame.
        bus_header(7'h50, 1'b0);
        bus_ack(a);
        chk("f037_part_aack", {31'd0, a}, 1);
        part = 8'b0000_1101;
        for (int i = 0; i < 4; i++) bus_bit(part[i]);
        bus_stop();
        exp_q.push_back(16'h3C50);
        frame(7'h50, 1'b0, 8'h3C, 1'b1, 1'b1, "f037");
        drain("f037");

        // Backpressure: second frame must be refused and flag overflow.
        set_ready(1'b0);
        exp_q.push_back(16'h1150);
        frame(7'h50, 1'b0, 8'h11, 1'b1, 1'b1, "f036a");
        chk("f036_hold1_tdata", {16'd0, m_axis.tdata}, 32'h1150);
        frame(7'h50, 1'b0, 8'h22, 1'b1, 1'b0, "f036b");
        chk("f036_hold2_tdata", {16'd0, m_axis.tdata}, 32'h1150);
        chk("f036_hold_tvalid", {31'd0, m_axis.tvalid}, 1);
        chk("f036_overflow", {31'd0, overflow}, 1);
        set_ready(1'b1);
        drain("f036");
        chk("f036_overflow_sticky", {31'd0, overflow}, 1);

        // Reset for two clocks in the middle of the data field.
        bus_header(7'h50, 1'b0);
        bus_ack(a);
        part = 8'h96;
        for (int i = 0; i < 3; i++) bus_bit(part[i]);
        @(negedge clk);
        arstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("f038_sda_oe", {31'd0, sda_oe}, 0);
        chk("f038_tvalid", {31'd0, m_axis.tvalid}, 0);
        chk("f038_tdata", {16'd0, m_axis.tdata}, 0);
        chk("f038_overflow", {31'd0, overflow}, 0);
        @(negedge clk);
        arstn = 1'b1;
        for (int i = 3; i < 8; i++) bus_bit(part[i]);
        bus_ack(a);
        chk("f038_tail_nack", {31'd0, a}, 0);
        bus_stop();
        drain("f038_tail");
        exp_q.push_back(16'h9650);
        frame(7'h50, 1'b0, 8'h96, 1'b1, 1'b1, "f038");
        drain("f038");

        // Read-direction frame at a slower scl, as a transmitter would send it.
        q_clk = 5;
        exp_q.push_back(16'hC3D0);
        frame(7'h50, 1'b1, 8'hC3, 1'b1, 1'b1, "f039");
        drain("f039");
        q_clk = 2;

        drain("final");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        failures = failures + 1;
        $display("FAIL timeout got=running exp=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end
endmodule
